// File: rtl/water_inlet_arbiter.sv
// Round-robin arbiter for the shared water-inlet valve, with a settle gap between grants.
// Optional fill-time limit with timeout pulse and lockout: define WATER_ARB_TIMEOUT_EN.
module water_inlet_arbiter #(
  parameter int N_MACH        = 4,
  parameter int FILL_CNT_1MHZ = 120,
  parameter int GAP_CYCLES    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        clk_freq,
  input  logic [N_MACH-1:0] req,
  output logic [N_MACH-1:0] grant,
  output logic              valve_open,
  output logic [N_MACH-1:0] timeout,
  output logic              busy
);

  localparam int IDXW = $clog2(N_MACH);
  localparam int GAPW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t            state_r;
  logic [IDXW-1:0]   last_r;
  logic [IDXW-1:0]   gidx_r;
  logic [N_MACH-1:0] grant_r;
  logic              valve_r;
  logic              busy_r;
  logic [GAPW-1:0]   gap_r;

  logic [N_MACH-1:0] lockout_s;
  logic [N_MACH-1:0] eligible_s;
  logic [IDXW-1:0]   pick_idx_s;
  logic              pick_valid_s;
  logic              req_g_s;

  // Index reached by stepping forward from base, wrapping at N_MACH.
  function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] base, input int step);
    int sum;
    sum = (int'(base) + step) % N_MACH;
    return IDXW'(sum);
  endfunction

`ifdef WATER_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(FILL_CNT_1MHZ * 8) + 1;

  logic [CNTW-1:0]   cnt_r;
  logic [CNTW-1:0]   limit_r;
  logic [CNTW-1:0]   limit_s;
  logic [N_MACH-1:0] lockout_r;
  logic [N_MACH-1:0] timeout_r;

  assign limit_s   = CNTW'(FILL_CNT_1MHZ) << clk_freq;
  assign lockout_s = lockout_r;
  assign timeout   = timeout_r;
`else
  logic unused_cfg_s;

  assign unused_cfg_s = (FILL_CNT_1MHZ > 0) ^ (^clk_freq);
  assign lockout_s    = '0;
  assign timeout      = '0;
`endif

  assign eligible_s = req & ~lockout_s;
  assign req_g_s    = req[gidx_r];
  assign grant      = grant_r;
  assign valve_open = valve_r;
  assign busy       = busy_r;

  // Round-robin search: walk downward so the nearest eligible index after last_r wins.
  always_comb begin
    pick_idx_s   = '0;
    pick_valid_s = 1'b0;
    for (int i = N_MACH; i >= 1; i--) begin
      pick_idx_s   = eligible_s[rr_idx(last_r, i)] ? rr_idx(last_r, i) : pick_idx_s;
      pick_valid_s = pick_valid_s | eligible_s[rr_idx(last_r, i)];
    end
  end

  // Arbitration FSM with registered grant, valve, busy and timeout outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      last_r    <= IDXW'(N_MACH - 1);
      gidx_r    <= '0;
      grant_r   <= '0;
      valve_r   <= 1'b0;
      busy_r    <= 1'b0;
      gap_r     <= '0;
`ifdef WATER_ARB_TIMEOUT_EN
      cnt_r     <= '0;
      limit_r   <= '0;
      lockout_r <= '0;
      timeout_r <= '0;
`endif
    end else begin
`ifdef WATER_ARB_TIMEOUT_EN
      timeout_r <= '0;
      lockout_r <= lockout_r & req;
`endif
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_r <= N_MACH'(1) << pick_idx_s;
            valve_r <= 1'b1;
            busy_r  <= 1'b1;
            last_r  <= pick_idx_s;
            gidx_r  <= pick_idx_s;
`ifdef WATER_ARB_TIMEOUT_EN
            cnt_r   <= CNTW'(1);
            limit_r <= limit_s;
`endif
            state_r <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // A release on the limit edge takes priority over the timeout.
          if (!req_g_s) begin
            grant_r <= '0;
            valve_r <= 1'b0;
            gap_r   <= '0;
            state_r <= ST_SETTLE;
          end
`ifdef WATER_ARB_TIMEOUT_EN
          else if (cnt_r == limit_r) begin
            grant_r   <= '0;
            valve_r   <= 1'b0;
            gap_r     <= '0;
            timeout_r <= grant_r;
            lockout_r <= (lockout_r & req) | grant_r;
            state_r   <= ST_SETTLE;
          end else begin
            cnt_r <= (cnt_r == {CNTW{1'b1}}) ? cnt_r : cnt_r + CNTW'(1);
          end
`else
          else begin
            state_r <= ST_GRANT;
          end
`endif
        end
        ST_SETTLE: begin
          if (gap_r == GAPW'(GAP_CYCLES - 1)) begin
            gap_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_r + GAPW'(1);
          end
        end
        default: begin
          grant_r <= '0;
          valve_r <= 1'b0;
          busy_r  <= 1'b0;
          gap_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
